// File: rtl/dec_arb_pkg.sv
// Shared types and constants for the decoder round-robin arbiter.
//   ADDR_W      : decoder address width (4 -> drives a 4-to-16 decoder)
//   N_REQ       : number of requesters, always 2**ADDR_W
//   dec_addr_t  : one decoder address / requester index
//   arb_state_t : arbiter FSM states, IDLE -> GRANT -> GAP -> IDLE
package dec_arb_pkg;
  localparam int ADDR_W = 4;
  localparam int N_REQ  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] dec_addr_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_t;
endpackage

// File: rtl/dec_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the decoder arbiter.
// Handshake: req[i] is a level request and stays high until requester i has
// been served; done is a one-cycle release pulse from the current owner and
// is only meaningful while en416 is high. en416/sel/busy/timeout are
// registered arbiter outputs. state mirrors the arbiter FSM for observation.
//   master  : requester side (drives req, done)
//   slave   : arbiter side   (drives en416, sel, busy, timeout, state)
interface dec_rr_arbiter_if;
  import dec_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic             en416;
  dec_addr_t        sel;
  logic             busy;
  logic             timeout;
  arb_state_t       state;

  modport master (
    output req, done,
    input  en416, sel, busy, timeout, state
  );

  modport slave (
    input  req, done,
    output en416, sel, busy, timeout, state
  );
endinterface

// File: rtl/dec_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder.
//   req    : request vector
//   ptr    : index with highest priority; priority falls off ptr, ptr+1, ... mod N_REQ
//   winner : first requesting index in that order (0 when none)
//   any    : at least one request present
module rr_pick
  import dec_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  dec_addr_t        ptr,
  output dec_addr_t        winner,
  output logic             any
);
  dec_addr_t idx;

  // Walk from lowest priority to highest so the last hit is the winner;
  // this avoids an early loop exit.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + dec_addr_t'(k);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dec_rr_arbiter.sv
// dec_rr_arbiter: round-robin arbiter sharing one 4-to-16 decoder select path
// among 16 requesters. The owner's address is driven on sel with en416 high
// until it releases (done pulse or request withdrawn); a one-cycle dead GAP
// always follows so decoder outputs break before the next owner makes.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dec_rr_arbiter_if.slave (req, done in; en416, sel, busy,
//              timeout, state out)
// Optional feature macro DEC_ARB_TIMEOUT_EN: limits each grant to MAX_HOLD
// cycles and pulses timeout on a forced release. Without it timeout is 0 and
// a grant is held until released by the owner.
module dec_rr_arbiter
  import dec_arb_pkg::*;
`ifdef DEC_ARB_TIMEOUT_EN
#(
  parameter int MAX_HOLD = 8
)
`endif
(
  input logic             clk,
  input logic             rst,
  dec_rr_arbiter_if.slave bus
);
  arb_state_t state_q;
  dec_addr_t  sel_q;
  dec_addr_t  ptr_q;
  logic       en416_q;
  logic       busy_q;
  dec_addr_t  winner;
  logic       any;
  logic       owner_release;
  logic       release_now;

  rr_pick u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any)
  );

  // Owner-initiated release: explicit done, or the owner dropped its request.
  assign owner_release = bus.done | ~bus.req[sel_q];

`ifdef DEC_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_expired;
  logic              timeout_q;

  assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign release_now  = owner_release | hold_expired;
  assign bus.timeout  = timeout_q;
`else
  assign release_now  = owner_release;
  assign bus.timeout  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      en416_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DEC_ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef DEC_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        ARB_IDLE: begin
          // sel keeps its last value while idle.
          if (any) begin
            sel_q   <= winner;
            en416_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ARB_GRANT;
`ifdef DEC_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        ARB_GRANT: begin
          if (release_now) begin
            en416_q <= 1'b0;
            ptr_q   <= sel_q + dec_addr_t'(1);  // owner drops to lowest priority
            state_q <= ARB_GAP;
`ifdef DEC_ARB_TIMEOUT_EN
            timeout_q <= ~owner_release;
`endif
          end else begin
`ifdef DEC_ARB_TIMEOUT_EN
            hold_cnt <= hold_cnt + HOLD_W'(1);
`endif
          end
        end
        ARB_GAP: begin
          // Dead cycle; requests are not looked at here.
          busy_q  <= 1'b0;
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
          en416_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.en416 = en416_q;
  assign bus.sel   = sel_q;
  assign bus.busy  = busy_q;
  assign bus.state = state_q;
endmodule
